pipe_addsub: RTL and testbench

Parametrised, pipelined N-bit adder/subtractor. Successor to the fixed 4-bit ripple-carry adder. The carry chain is split into STAGES equal chunks, with one chunk resolved per clock, so WIDTH scales without lengthening the critical path. Valid/ready handshakes on input and output let it sit directly in datapath streams (ALU, accumulators, address generators).

---
 rtl/pipe_addsub.sv | 123 ++++++++++++
 tb/tb_pipe_addsub.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: the carry chain is cut into STAGES chunks,
// one chunk resolved per clock, with valid/ready handshakes on both sides.
module pipe_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int CHUNK = WIDTH / STAGES;

    function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             c);
        return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c};
    endfunction

    logic             stall;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // Subtraction is a + ~b + ~cin, so a borrow-in becomes a dropped carry-in.
    assign b_eff = op_sub ? ~b : b;
    assign c0    = op_sub ? ~cin : cin;

    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int SW = (k + 1) * CHUNK;

        logic [CHUNK-1:0] xa;
        logic [CHUNK-1:0] yb;
        logic             c_in;
        logic             sa_in;
        logic             sb_in;
        logic             v_in;
        logic [SW-1:0]    sum_nxt;
        logic [CHUNK:0]   r;

        logic [SW-1:0]    sum_p;
        logic             c_p;
        logic             sa_p;
        logic             sb_p;
        logic             vld_p;

        assign r = chunk_add(xa, yb, c_in);

        if (k == 0) begin : g_in
            assign xa      = a[CHUNK-1:0];
            assign yb      = b_eff[CHUNK-1:0];
            assign c_in    = c0;
            assign sa_in   = a[WIDTH-1];
            assign sb_in   = b_eff[WIDTH-1];
            assign v_in    = in_valid;
            assign sum_nxt = r[CHUNK-1:0];
        end else begin : g_in
            assign xa      = stg[k-1].g_skew.opa_p[CHUNK-1:0];
            assign yb      = stg[k-1].g_skew.opb_p[CHUNK-1:0];
            assign c_in    = stg[k-1].c_p;
            assign sa_in   = stg[k-1].sa_p;
            assign sb_in   = stg[k-1].sb_p;
            assign v_in    = stg[k-1].vld_p;
            assign sum_nxt = {r[CHUNK-1:0], stg[k-1].sum_p};
        end

        // ---- stage k boundary: resolved sum chunks, carry, sign bits, valid ----
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_p <= 1'b0;
                sum_p <= '0;
                c_p   <= 1'b0;
                sa_p  <= 1'b0;
                sb_p  <= 1'b0;
            end else if (!stall) begin
                vld_p <= v_in;
                sum_p <= sum_nxt;
                c_p   <= r[CHUNK];
                sa_p  <= sa_in;
                sb_p  <= sb_in;
            end
        end

        // Operand chunks not consumed yet; each stage peels off the lowest one.
        if (k < STAGES - 1) begin : g_skew
            localparam int UW = WIDTH - SW;
            logic [UW-1:0] opa_p;
            logic [UW-1:0] opb_p;

            if (k == 0) begin : g_src
                always_ff @(posedge clk) begin
                    if (!stall) begin
                        opa_p <= a[WIDTH-1:CHUNK];
                        opb_p <= b_eff[WIDTH-1:CHUNK];
                    end
                end
            end else begin : g_src
                always_ff @(posedge clk) begin
                    if (!stall) begin
                        opa_p <= stg[k-1].g_skew.opa_p[UW+CHUNK-1:CHUNK];
                        opb_p <= stg[k-1].g_skew.opb_p[UW+CHUNK-1:CHUNK];
                    end
                end
            end
        end
    end

    assign out_valid = stg[STAGES-1].vld_p;
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;

    assign s    = stg[STAGES-1].sum_p;
    assign cout = stg[STAGES-1].c_p;
    assign ovf  = (stg[STAGES-1].sa_p == stg[STAGES-1].sb_p) && (s[WIDTH-1] != stg[STAGES-1].sa_p);
endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub: directed cases, backpressure, reset mid-flight,
// a single-stage 8-bit instance and a randomized run against an arithmetic model.
module tb_pipe_addsub;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        op_sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] s;
    logic        cout;
    logic        ovf;

    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        cin8 = 1'b0;
    logic        sub8 = 1'b0;
    logic        out_valid8;
    logic        out_ready8 = 1'b1;
    logic [7:0]  s8;
    logic        cout8;
    logic        ovf8;

    int n_checks = 0;
    int n_err    = 0;

    pipe_addsub #(.WIDTH(16), .STAGES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .op_sub(op_sub), .out_valid(out_valid),
        .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf)
    );

    pipe_addsub #(.WIDTH(8), .STAGES(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .op_sub(sub8), .out_valid(out_valid8),
        .out_ready(out_ready8), .s(s8), .cout(cout8), .ovf(ovf8)
    );

    always #5 clk = ~clk;

    // Returns {cout, ovf, s} computed with plain integer arithmetic for a w-bit adder.
    function automatic logic [17:0] ref_op(input int w, input int x, input int y,
                                           input int c, input int sub);
        int  full = 1 << w;
        int  half = 1 << (w - 1);
        int  sx   = (x >= half) ? x - full : x;
        int  sy   = (y >= half) ? y - full : y;
        int  res_u;
        int  res_s;
        bit  co;
        bit  ov;
        if (sub == 0) begin
            res_u = x + y + c;
            res_s = sx + sy + c;
            co    = (res_u >= full);
        end else begin
            res_u = x - y - c;
            res_s = sx - sy - c;
            co    = (res_u >= 0);
        end
        ov = (res_s >= half) || (res_s < -half);
        return {co, ov, 16'(res_u & (full - 1))};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_valid8 = 1'b1;
        a         = 16'h1234;
        b         = 16'h4321;
        tick();
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++;
        if ({cout, ovf, s} !== 18'h0) begin n_err++; $display("FAIL reset_outputs: got %h expected 0", {cout, ovf, s}); end
        n_checks++;
        if ({out_valid8, cout8, ovf8, s8} !== 11'h0) begin
            n_err++; $display("FAIL reset_small: got %h expected 0", {out_valid8, cout8, ovf8, s8});
        end
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_valid8 = 1'b0;
        tick();
        n_checks++;
        if ({in_ready, in_ready8, out_valid} !== 3'b110) begin
            n_err++; $display("FAIL reset_release: got %b expected 110", {in_ready, in_ready8, out_valid});
        end
    endtask

    task automatic do_op(input string name, input logic [15:0] x, input logic [15:0] y,
                         input logic c, input logic sub,
                         input logic [15:0] es, input logic ec, input logic eo);
        int cnt;
        a = x; b = y; cin = c; op_sub = sub;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL %s_in_ready: got %b expected 1", name, in_ready); end
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            if (cnt == 0) begin
                in_valid = 1'b0;
                a = 16'($urandom);
                b = 16'($urandom);
                cin = 1'($urandom);
                op_sub = 1'($urandom);
            end
            cnt++;
        end while (!out_valid && cnt < 20);
        n_checks++;
        if (cnt != 4) begin n_err++; $display("FAIL %s_latency: got %0d expected 4", name, cnt); end
        n_checks++;
        if ({cout, ovf, s} !== {ec, eo, es}) begin
            n_err++; $display("FAIL %s_result: got cout=%b ovf=%b s=%h expected cout=%b ovf=%b s=%h",
                              name, cout, ovf, s, ec, eo, es);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL %s_drain: got out_valid=%b expected 0", name, out_valid); end
    endtask

    task automatic test_add();
        do_op("add", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        do_op("add_wrap_ovf", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    endtask

    task automatic test_carry();
        do_op("carry_chain", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("signed_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    endtask

    task automatic test_sub();
        do_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        do_op("sub_borrow", 16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op("sub_borrow_in", 16'h0010, 16'h0005, 1'b1, 1'b1, 16'h000A, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        int          issued = 0;
        int          got    = 0;
        int          cyc    = 0;
        int          first  = -1;
        logic        stall_prev = 1'b0;
        logic [17:0] held = '0;
        while (got < 6 && cyc < 40) begin
            if (stall_prev) begin
                n_checks++;
                if ({out_valid, cout, ovf, s} !== {1'b1, held}) begin
                    n_err++; $display("FAIL bp_hold: got %h expected %h", {out_valid, cout, ovf, s}, {1'b1, held});
                end
            end
            in_valid = (issued < 6);
            a        = 16'(issued + 1);
            b        = 16'h1000;
            cin      = 1'b0;
            op_sub   = 1'b0;
            if (out_valid && first < 0) first = cyc;
            out_ready = !(first >= 0 && cyc - first < 3);
            #1;
            if (out_valid && !out_ready) begin
                n_checks++;
                if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
            end
            if (out_ready && got > 0) begin
                n_checks++;
                if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_gap: got out_valid=%b expected 1 after %0d results", out_valid, got); end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if ({cout, ovf, s} !== {2'b00, 16'(32'h1001 + got)}) begin
                    n_err++; $display("FAIL bp_order: got %h expected %h", {cout, ovf, s}, {2'b00, 16'(32'h1001 + got)});
                end
                got++;
            end
            if (in_valid && in_ready) issued++;
            stall_prev = out_valid && !out_ready;
            held       = {cout, ovf, s};
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (got != 6) begin n_err++; $display("FAIL bp_count: got %0d expected 6", got); end
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        cin = 1'b0; op_sub = 1'b0;
        in_valid = 1'b1; a = 16'h0001; b = 16'h0101;
        tick();
        a = 16'h0002;
        tick();
        a = 16'h0003;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL rmid_in_ready: got %b expected 1", in_ready); end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_stale: got out_valid=%b s=%h expected 0 at cycle %0d", out_valid, s, i); end
            tick();
        end
        do_op("post_reset", 16'h1234, 16'h0101, 1'b0, 1'b0, 16'h1335, 1'b0, 1'b0);
    endtask

    task automatic test_small();
        logic [17:0] exp;
        out_ready8 = 1'b1;
        a8 = 8'hF0; b8 = 8'h20; cin8 = 1'b0; sub8 = 1'b0; in_valid8 = 1'b1;
        #1;
        n_checks++;
        if (in_ready8 !== 1'b1) begin n_err++; $display("FAIL small_in_ready: got %b expected 1", in_ready8); end
        tick();
        in_valid8 = 1'b0;
        n_checks++;
        if ({out_valid8, cout8, ovf8, s8} !== {3'b110, 8'h10}) begin
            n_err++; $display("FAIL small_directed: got %h expected %h", {out_valid8, cout8, ovf8, s8}, {3'b110, 8'h10});
        end
        tick();
        n_checks++;
        if (out_valid8 !== 1'b0) begin n_err++; $display("FAIL small_drain: got %b expected 0", out_valid8); end
        for (int i = 0; i < 200; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
            in_valid8 = 1'b1;
            exp = ref_op(8, int'(a8), int'(b8), int'(cin8), int'(sub8));
            tick();
            n_checks++;
            if ({out_valid8, cout8, ovf8, s8} !== {1'b1, exp[17:16], exp[7:0]}) begin
                n_err++; $display("FAIL small_rand: got %h expected %h", {out_valid8, cout8, ovf8, s8}, {1'b1, exp[17:16], exp[7:0]});
            end
        end
        in_valid8 = 1'b0;
        tick();
    endtask

    function automatic logic [15:0] pick_operand();
        logic [15:0] corner [4] = '{16'hFFFF, 16'h8000, 16'h7FFF, 16'h0000};
        if ($urandom_range(0, 7) == 0) return corner[$urandom_range(0, 3)];
        return 16'($urandom);
    endfunction

    task automatic test_random();
        logic [17:0] q[$];
        logic [17:0] exp;
        logic [17:0] held = '0;
        logic        stall_prev = 1'b0;
        int          acc = 0;
        int          cyc = 0;
        while ((acc < 10000 || q.size() > 0) && cyc < 60000) begin
            if (stall_prev) begin
                n_checks++;
                if ({out_valid, cout, ovf, s} !== {1'b1, held}) begin
                    n_err++; $display("FAIL rand_hold: got %h expected %h", {out_valid, cout, ovf, s}, {1'b1, held});
                end
            end
            in_valid  = (acc < 10000) && ($urandom_range(0, 3) != 0);
            a         = pick_operand();
            b         = pick_operand();
            cin       = 1'($urandom);
            op_sub    = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            n_checks++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                n_err++; $display("FAIL rand_in_ready: got %b with out_valid=%b out_ready=%b", in_ready, out_valid, out_ready);
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_err++; $display("FAIL rand_spurious: got s=%h with nothing outstanding", s);
                end else begin
                    exp = q.pop_front();
                    if ({cout, ovf, s} !== exp) begin
                        n_err++; $display("FAIL rand_result: got %h expected %h", {cout, ovf, s}, exp);
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_op(16, int'(a), int'(b), int'(cin), int'(op_sub)));
                acc++;
            end
            stall_prev = out_valid && !out_ready;
            held       = {cout, ovf, s};
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (acc != 10000 || q.size() != 0) begin
            n_err++; $display("FAIL rand_complete: got %0d accepted %0d outstanding expected 10000 and 0", acc, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_carry();
        test_sub();
        test_backpressure();
        test_reset_mid();
        test_small();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
